cmd_fetch: RTL
==============

# cmd_fetch

Command fetch stage that feeds the command scheduler. On each fetch request (rising edge of `dma_p1_reads_en`), it issues one SDRAM read burst on memory port 1 for the next command record, `CMD_BURST_LEN` 32-bit words long. It then streams the returned words to the scheduler as `cmd`, qualified by the single-cycle strobe `dma_p1_ob_we`. It tracks the command index, stops at `cmd_size`, and can be restarted for re-execution of the command list.

## Interface
- `CMD_BURST_LEN`, default 8: words per command record (8 × 32 bit = 256 bit).
- `CMD_BASE_ADDR`, default 30'h000_0000: byte address of command 0 in SDRAM.
- `clk`  in  1  single clock for the block; also the memory-port clock.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch_restart`  in  1  one-cycle pulse; clears the command index and the overrun flag.
- `cmd_size`  in  7  number of commands in the list; sampled at each request.
- `dma_p1_reads_en`  in  1  fetch request from the scheduler; a rising edge requests one command; held high while the scheduler is collecting.
- `cmd`  out  32  current command word; changes only in the cycle `dma_p1_ob_we` is high.
- `dma_p1_ob_we`  out  1  one-cycle strobe marking a new word on `cmd`.
- `mem_cmd_en`  out  1  memory command strobe.
- `mem_cmd_instr`  out  3  memory instruction; always 3'b001 (read).
- `mem_cmd_bl`  out  6  burst length minus one, i.e. `CMD_BURST_LEN-1`.
- `mem_cmd_byte_addr`  out  30  burst start address.
- `mem_cmd_full`  in  1  memory command queue is full.
- `mem_rd_en`  out  1  read-data pop; combinational.
- `mem_rd_data`  in  32  read data, first-word-fall-through.
- `mem_rd_empty`  in  1  read-data FIFO is empty.
- `cmd_idx`  out  7  index of the next command to fetch.
- `fetch_busy`  out  1  high in ISSUE, READ and FLUSH.
- `fetch_overrun`  out  1  sticky; set when a request arrives with `cmd_idx >= cmd_size`.

## Operation
- Request detection:
  - `req_rise = dma_p1_reads_en & ~reads_en_d`; `reads_en_d` is a register with reset value 0.
  - A rise seen outside IDLE sets `pending`, which is served on the next return to IDLE.
- States: IDLE, ISSUE, READ, FLUSH.
- **IDLE**
  - On (`req_rise` | `pending`): if `cmd_idx < cmd_size`, go to ISSUE.
  - Otherwise set `fetch_overrun`, stay in IDLE and issue no memory traffic.
  - `pending` clears when it is consumed.
- **ISSUE**
  - Drive `mem_cmd_en=1` and `mem_cmd_byte_addr = CMD_BASE_ADDR + cmd_idx*CMD_BURST_LEN*4`. Compute this in 30 bits; wrap-around is allowed.
  - The command is accepted in a cycle where `mem_cmd_full=0`; then go to READ with `word_cnt=0`.
  - While `mem_cmd_full=1`, `mem_cmd_en` stays low and the block stays in ISSUE.
- **READ**
  - `mem_rd_en = ~mem_rd_empty`.
  - On each pop: next cycle `cmd <= mem_rd_data`, `dma_p1_ob_we <= 1`, and `word_cnt` increments.
  - After pop number `CMD_BURST_LEN`: `cmd_idx` increments and the state returns to IDLE.
  - If `dma_p1_reads_en` is low while in READ (request withdrawn), go to FLUSH.
- **FLUSH**
  - Keep popping until `word_cnt == CMD_BURST_LEN`, with `dma_p1_ob_we` suppressed.
  - Then return to IDLE. `cmd_idx` is not incremented, so the same command is refetched on the next request.
- **fetch_restart**
  - In IDLE or ISSUE before acceptance: immediately `cmd_idx<=0`, `fetch_overrun<=0`, `pending<=0`, and the state goes to IDLE.
  - In READ or FLUSH: go to FLUSH (or stay in it), with `restart_pend=1`. On FLUSH exit, clear `cmd_idx` and `fetch_overrun`.
  - Restart wins over a simultaneous `req_rise`; that request is dropped.
- Words are forwarded strictly in memory order, with at most one per cycle. Gaps appear only while `mem_rd_empty=1`.

## Timing
- Reset values:
  - `cmd`=0, `dma_p1_ob_we`=0, `mem_cmd_en`=0, `mem_cmd_byte_addr`=0, `mem_rd_en`=0.
  - `cmd_idx`=0, `fetch_busy`=0, `fetch_overrun`=0.
  - State IDLE; `pending`, `restart_pend`, `reads_en_d` all 0.
- `mem_cmd_instr` and `mem_cmd_bl` are constant.
- Reset mid-burst returns to IDLE in one cycle. Words still in the memory FIFO are not the block's concern after reset.
- Cycle numbering from a rise of `dma_p1_reads_en` sampled at edge t:
  - ISSUE at t+1, with `mem_cmd_en` high at t+1 if `mem_cmd_full=0`.
  - READ at t+2; the first pop is at t+2 if data is present.
  - First `dma_p1_ob_we` at t+3.
  - With data always available, the last strobe is at t+2+`CMD_BURST_LEN`.
- `dma_p1_ob_we` is never high for two cycles on the same word. `cmd` is stable between strobes.
- `fetch_busy` is registered and tracks the state, one cycle after the transition.

## Test plan
- Basic fetch:
  - Stimulus: `cmd_size`=2, memory returns 0x11..0x18 with no empty gaps, request rise at t.
  - Response: one `mem_cmd_en` at t+1 with addr 0x00; eight strobes t+3..t+10 carrying 0x11..0x18 in order; `cmd_idx`=1.
- Second command address:
  - Stimulus: a further request.
  - Response: addr 0x20, `cmd_idx`=2. A third request sets `fetch_overrun`=1 with no `mem_cmd_en`.
- Backpressure:
  - Stimulus: `mem_cmd_full` high for 5 cycles, then `mem_rd_empty` toggling every other cycle.
  - Response: `mem_cmd_en` only after full drops; strobes only on cycles following pops; exactly 8 strobes.
- Withdrawal:
  - Stimulus: `dma_p1_reads_en` dropped after 3 strobes.
  - Response: the remaining 5 words are popped with no strobes; `cmd_idx` is unchanged; the next request refetches the same address.
- Restart mid-READ:
  - Stimulus: `fetch_restart` pulsed after 2 words with `cmd_idx`=1.
  - Response: the burst is flushed; then `cmd_idx`=0 and `fetch_overrun`=0; the next request uses addr 0x00.
- Reset mid-burst:
  - Stimulus: `rst` asserted during READ.
  - Response: all outputs at reset values on the next cycle; no strobe afterwards.

Source files
------------

// File: rtl/cmd_fetch.sv
// Command fetch stage: issues one SDRAM read burst per scheduler request and
// streams the returned command words to the scheduler, tracking the command index.
module cmd_fetch #(
  parameter int unsigned CMD_BURST_LEN = 8,
  parameter logic [29:0] CMD_BASE_ADDR = 30'h000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_restart,
  input  logic [6:0]  cmd_size,
  input  logic        dma_p1_reads_en,
  output logic [31:0] cmd,
  output logic        dma_p1_ob_we,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_full,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_empty,
  output logic [6:0]  cmd_idx,
  output logic        fetch_busy,
  output logic        fetch_overrun
);

  typedef enum logic [1:0] {StIdle, StIssue, StRead, StFlush} state_e;

  localparam logic [6:0]  LastWord   = 7'(CMD_BURST_LEN - 1);
  localparam logic [29:0] BurstBytes = 30'(CMD_BURST_LEN * 4);

  state_e      state_q, state_d;
  logic        reads_en_q;
  logic        pending_q, pending_d;
  logic        restart_pend_q, restart_pend_d;
  logic [6:0]  word_cnt_q, word_cnt_d;
  logic [6:0]  cmd_idx_q, cmd_idx_d;
  logic        overrun_q, overrun_d;
  logic [31:0] cmd_q, cmd_d;
  logic        ob_we_q, ob_we_d;
  logic        busy_q;

  logic        req_rise;
  logic        last_pop;
  logic        withdraw;
  logic        restart_any;
  logic [29:0] burst_addr;

  assign req_rise    = dma_p1_reads_en & ~reads_en_q;
  assign last_pop    = (word_cnt_q == LastWord);
  // A withdrawn request or a restart turns the rest of the burst into a silent drain.
  assign withdraw    = ~dma_p1_reads_en | fetch_restart;
  assign restart_any = restart_pend_q | fetch_restart;
  assign burst_addr  = CMD_BASE_ADDR + 30'(cmd_idx_q) * BurstBytes;

  always_comb begin
    state_d           = state_q;
    pending_d         = pending_q;
    restart_pend_d    = restart_pend_q;
    word_cnt_d        = word_cnt_q;
    cmd_idx_d         = cmd_idx_q;
    overrun_d         = overrun_q;
    cmd_d             = cmd_q;
    ob_we_d           = 1'b0;
    mem_cmd_en        = 1'b0;
    mem_cmd_byte_addr = '0;
    mem_rd_en         = 1'b0;

    // Restart drops any request seen in the same cycle.
    if (fetch_restart) begin
      pending_d = 1'b0;
    end else if (req_rise && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (fetch_restart) begin
          cmd_idx_d = '0;
          overrun_d = 1'b0;
        end else if (req_rise || pending_q) begin
          pending_d = 1'b0;
          if (cmd_idx_q < cmd_size) begin
            state_d = StIssue;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end

      StIssue: begin
        mem_cmd_byte_addr = burst_addr;
        if (fetch_restart) begin
          cmd_idx_d = '0;
          overrun_d = 1'b0;
          state_d   = StIdle;
        end else if (!mem_cmd_full) begin
          mem_cmd_en = 1'b1;
          word_cnt_d = '0;
          state_d    = StRead;
        end
      end

      StRead, StFlush: begin
        mem_rd_en = ~mem_rd_empty;
        if (fetch_restart) begin
          restart_pend_d = 1'b1;
        end
        if (mem_rd_en) begin
          word_cnt_d = word_cnt_q + 7'd1;
          if ((state_q == StRead) && !withdraw) begin
            ob_we_d = 1'b1;
            cmd_d   = mem_rd_data;
          end
        end
        if (mem_rd_en && last_pop) begin
          state_d = StIdle;
          if ((state_q == StRead) && !withdraw) begin
            cmd_idx_d = cmd_idx_q + 7'd1;
          end else if (restart_any) begin
            cmd_idx_d      = '0;
            overrun_d      = 1'b0;
            restart_pend_d = 1'b0;
          end
        end else if (withdraw) begin
          state_d = StFlush;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      reads_en_q     <= 1'b0;
      pending_q      <= 1'b0;
      restart_pend_q <= 1'b0;
      word_cnt_q     <= '0;
      cmd_idx_q      <= '0;
      overrun_q      <= 1'b0;
      cmd_q          <= '0;
      ob_we_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      reads_en_q     <= dma_p1_reads_en;
      pending_q      <= pending_d;
      restart_pend_q <= restart_pend_d;
      word_cnt_q     <= word_cnt_d;
      cmd_idx_q      <= cmd_idx_d;
      overrun_q      <= overrun_d;
      cmd_q          <= cmd_d;
      ob_we_q        <= ob_we_d;
      busy_q         <= (state_d != StIdle);
    end
  end

  assign cmd           = cmd_q;
  assign dma_p1_ob_we  = ob_we_q;
  assign mem_cmd_instr = 3'b001;
  assign mem_cmd_bl    = 6'(CMD_BURST_LEN - 1);
  assign cmd_idx       = cmd_idx_q;
  assign fetch_busy    = busy_q;
  assign fetch_overrun = overrun_q;

endmodule
